// File: rtl/config_pkg.sv
// Shared definitions for the configuration bitstream transmitter:
// FSM state encoding and default frame geometry.
package config_pkg;

    localparam int DEF_FRAME_BITS = 26;
    localparam int DEF_NUM_FRAMES = 3;
    localparam int DEF_PAD_BITS   = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        SHIFT  = 3'd2,
        FLUSH  = 3'd3,
        FINISH = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/cfg_frame_buf.sv
// One-entry valid/ready frame register used as the prefetch buffer.
// Ports: clk, reset, clear (drop contents), accept_en (window in which
// the buffer may take a frame), in_valid/in_data/in_ready (upstream
// handshake), pop (contents consumed), full, out_data.
module cfg_frame_buf #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         accept_en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         pop,
    output logic         full,
    output logic [W-1:0] out_data
);

    logic take;

    assign in_ready = accept_en && !full;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            full     <= 1'b0;
            out_data <= '0;
        end else if (take) begin
            full     <= 1'b1;
            out_data <= in_data;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/config_stream_tx.sv
// Serialises NUM_FRAMES configuration frames (LSB first, gap-free) onto
// the fabric chain, followed by PAD_BITS zero flush bits.
// Ports: clk, reset (sync, active-high), start, frame_data/frame_valid/
// frame_ready (frame input), bit_in_CB, prgm_b, cb_prgm_b (fabric side),
// busy, done (one-cycle pulse), underrun (sticky error).
module config_stream_tx
    import config_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int PAD_BITS   = DEF_PAD_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame_data,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic                  bit_in_CB,
    output logic                  prgm_b,
    output logic                  cb_prgm_b,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam int BCW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int FCW = $clog2(NUM_FRAMES + 1);
    localparam int PCW = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;

    localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_BITS - 1);
    localparam logic [FCW-1:0] FRM_LAST = FCW'(NUM_FRAMES - 1);
    localparam logic [PCW-1:0] PAD_LAST =
        PCW'((PAD_BITS > 0) ? PAD_BITS - 1 : 0);

    state_t                  state, state_n;
    logic [FRAME_BITS-1:0]   shreg;
    logic [BCW-1:0]          bit_cnt;
    logic [FCW-1:0]          frame_cnt;
    logic [PCW-1:0]          pad_cnt;

    logic                    buf_accept, buf_pop, buf_full;
    logic [FRAME_BITS-1:0]   buf_data;
    logic                    sess_start, load_sh, shift_en;
    logic                    flush_en, set_ur;

    cfg_frame_buf #(.W(FRAME_BITS)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (sess_start),
        .accept_en (buf_accept),
        .in_valid  (frame_valid),
        .in_data   (frame_data),
        .in_ready  (frame_ready),
        .pop       (buf_pop),
        .full      (buf_full),
        .out_data  (buf_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        prgm_b     = 1'b1;
        cb_prgm_b  = 1'b0;
        bit_in_CB  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        buf_accept = 1'b0;
        buf_pop    = 1'b0;
        sess_start = 1'b0;
        load_sh    = 1'b0;
        shift_en   = 1'b0;
        flush_en   = 1'b0;
        set_ur     = 1'b0;
        unique case (state)
            IDLE, ERR: begin
                if (start) begin
                    state_n    = PRIME;
                    sess_start = 1'b1;
                end
            end
            PRIME: begin
                busy       = 1'b1;
                buf_accept = 1'b1;
                if (buf_full) begin
                    load_sh = 1'b1;
                    buf_pop = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                prgm_b    = 1'b0;
                cb_prgm_b = 1'b1;
                bit_in_CB = shreg[0];
                busy      = 1'b1;
                shift_en  = 1'b1;
                // only prefetch frames that still belong to this session
                buf_accept = (frame_cnt < FRM_LAST);
                if (bit_cnt == BIT_LAST) begin
                    if (frame_cnt == FRM_LAST) begin
                        state_n = (PAD_BITS > 0) ? FLUSH : FINISH;
                    end else if (buf_full) begin
                        load_sh = 1'b1;
                        buf_pop = 1'b1;
                    end else begin
                        state_n = ERR;
                        set_ur  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                prgm_b    = 1'b0;
                cb_prgm_b = 1'b1;
                busy      = 1'b1;
                flush_en  = 1'b1;
                if (pad_cnt == PAD_LAST) state_n = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            pad_cnt   <= '0;
            underrun  <= 1'b0;
        end else begin
            if (sess_start) begin
                bit_cnt   <= '0;
                frame_cnt <= '0;
                pad_cnt   <= '0;
                underrun  <= 1'b0;
            end
            if (set_ur) underrun <= 1'b1;
            // a reload on the last bit takes priority over the shift
            if (load_sh)       shreg <= buf_data;
            else if (shift_en) shreg <= shreg >> 1;
            if (shift_en) begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt   <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (flush_en) pad_cnt <= pad_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_config_stream_tx.sv
// Directed self-checking bench for config_stream_tx.
// Ports: none (drives the DUT and prints one summary line).
module tb_config_stream_tx;

    localparam int FB  = 26;
    localparam int NF  = 3;
    localparam int PB  = 2;
    localparam int TOT = FB * NF;
    localparam int SL  = TOT + PB;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic          bit_in_CB;
    logic          prgm_b;
    logic          cb_prgm_b;
    logic          busy;
    logic          done;
    logic          underrun;

    config_stream_tx #(
        .FRAME_BITS (FB),
        .NUM_FRAMES (NF),
        .PAD_BITS   (PB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .bit_in_CB   (bit_in_CB),
        .prgm_b      (prgm_b),
        .cb_prgm_b   (cb_prgm_b),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [FB-1:0] frames [NF];
    logic          exp_s  [SL];
    logic          cap    [SL];
    logic          str_a  [SL];
    logic          str_b  [SL];
    int            fidx;
    int            avail;
    int            hs_count;
    int            lat;
    int            diff;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_frames();
        frame_valid = (fidx < avail);
        frame_data  = frames[fidx % NF];
    endtask

    // one clock: record handshake seen before the edge, sample #1 after
    task automatic cycle();
        logic hs;
        hs = frame_valid && frame_ready;
        @(posedge clk);
        #1;
        if (hs) begin
            fidx++;
            hs_count++;
        end
        start = 1'b0;
        drive_frames();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_prgm_b"}, prgm_b, 1);
        chk({tag, "_cb_prgm_b"}, cb_prgm_b, 0);
        chk({tag, "_bit"}, bit_in_CB, 0);
        chk({tag, "_ready"}, frame_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_underrun"}, underrun, 0);
    endtask

    task automatic begin_session(input int nav);
        fidx     = 0;
        hs_count = 0;
        avail    = nav;
        drive_frames();
        start = 1'b1;
        cycle();
        lat = 0;
        while (cb_prgm_b !== 1'b1 && lat < 10) begin
            cycle();
            lat++;
        end
        chk("first_shift_latency", lat, 2);
    endtask

    task automatic run_full(input bit poke_start);
        begin_session(99);
        for (int n = 0; n < SL; n++) begin
            cap[n] = bit_in_CB;
            chk($sformatf("bit%0d", n), bit_in_CB, exp_s[n]);
            chk($sformatf("cb%0d", n), cb_prgm_b, 1);
            if (n >= TOT)
                chk($sformatf("ready_flush%0d", n), frame_ready, 0);
            if (poke_start && n == 10) start = 1'b1;
            cycle();
        end
        chk("fin_done", done, 1);
        chk("fin_prgm_b", prgm_b, 1);
        chk("fin_cb_prgm_b", cb_prgm_b, 0);
        chk("fin_busy", busy, 0);
        chk("fin_ready", frame_ready, 0);
        cycle();
        chk("idle_done", done, 0);
        chk("idle_ready", frame_ready, 0);
        chk("idle_busy", busy, 0);
        chk("handshakes", hs_count, NF);
    endtask

    initial begin
        frames[0] = 26'b11010000000000000000000011;
        frames[1] = 26'b10110000000000000000000001;
        frames[2] = 26'b11100000000000000000000001;
        for (int f = 0; f < NF; f++) begin
            logic [FB-1:0] fr;
            fr = frames[f];
            for (int k = 0; k < FB; k++) exp_s[f*FB+k] = fr[k];
        end
        for (int p = 0; p < PB; p++) exp_s[TOT+p] = 1'b0;

        reset       = 1'b1;
        start       = 1'b0;
        frame_valid = 1'b0;
        frame_data  = '0;
        fidx        = 0;
        avail       = 0;
        hs_count    = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        reset = 1'b0;
        cycle();
        chk_reset_outs("idle");

        // valid offered while idle is never consumed
        avail = 99;
        drive_frames();
        cycle();
        cycle();
        chk("idle_no_ready", frame_ready, 0);
        chk("idle_no_hs", hs_count, 0);

        // session A, then session B started right after done,
        // with a start pulse poked into the middle of its stream
        run_full(1'b0);
        str_a = cap;
        run_full(1'b1);
        str_b = cap;
        diff = 0;
        for (int n = 0; n < SL; n++)
            if (str_a[n] !== str_b[n]) diff++;
        chk("b2b_diff", diff, 0);

        // frame 1 withheld: underrun at end of frame 0
        begin_session(1);
        for (int n = 0; n < FB; n++) begin
            chk($sformatf("ur_bit%0d", n), bit_in_CB, exp_s[n]);
            cycle();
        end
        chk("err_underrun", underrun, 1);
        chk("err_cb_prgm_b", cb_prgm_b, 0);
        chk("err_prgm_b", prgm_b, 1);
        chk("err_bit", bit_in_CB, 0);
        chk("err_busy", busy, 0);
        chk("err_done", done, 0);
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("err_hold_done", done, 0);
            chk("err_hold_ur", underrun, 1);
        end
        chk("err_hs", hs_count, 1);
        start = 1'b1;
        cycle();
        chk("err_restart_ur", underrun, 0);
        chk("err_restart_busy", busy, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();

        // reset in the middle of the stream
        begin_session(99);
        for (int n = 0; n < 40; n++) cycle();
        chk("mid_bit40", bit_in_CB, exp_s[40]);
        reset = 1'b1;
        cycle();
        chk_reset_outs("midrst");
        reset = 1'b0;
        avail = 0;
        drive_frames();
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("midrst_no_done", done, 0);
        end
        start = 1'b1;
        cycle();
        chk("midrst_prime_busy", busy, 1);
        chk("midrst_buf_empty", frame_ready, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_stream_tx.md
CONFIG_STREAM_TX -- requirements
Module: config_stream_tx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 26, meaning configuration bits per LUT frame.
REQ-002 SHALL have parameter NUM_FRAMES, default 3, meaning frames per programming session.
REQ-003 SHALL have parameter PAD_BITS, default 2, meaning zero flush bits after the last frame (switch-box chain depth).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a session; ignored unless idle.
REQ-008 frame_data  in  FRAME_BITS  frame payload, bit 0 shifted first.
REQ-009 frame_valid  in  1  frame_data is valid.
REQ-010 frame_ready  out  1  prefetch buffer empty; a frame is accepted when frame_valid and frame_ready are both high.
REQ-011 bit_in_CB  out  1  serial configuration bit to the fabric chain.
REQ-012 prgm_b  out  1  active-low programming window.
REQ-013 cb_prgm_b  out  1  active-high configuration-bit shift enable.
REQ-014 busy  out  1  session in progress.
REQ-015 done  out  1  one-cycle pulse on successful completion.
REQ-016 underrun  out  1  sticky error flag, cleared by start or reset.

Function
REQ-017 SHALL implement FSM states IDLE, PRIME, SHIFT, FLUSH, FINISH, ERR.
REQ-018 IDLE: start -> PRIME, clearing underrun, frame counter and bit counter; otherwise remain.
REQ-019 SHALL hold one-frame prefetch buffer; frame_ready = buffer empty AND state in {PRIME, SHIFT}.
REQ-020 PRIME: prgm_b=1, cb_prgm_b=0; when buffer is full, SHALL move buffer to shift register and enter SHIFT next cycle.
REQ-021 SHIFT: prgm_b=0, cb_prgm_b=1, bit_in_CB = shift register bit 0; register shifts right by one bit each cycle.
REQ-022 Bit k of frame f SHALL appear on bit_in_CB exactly f*FRAME_BITS+k cycles after the first SHIFT cycle: no gaps between frames.
REQ-023 On the last bit of a non-final frame, buffer full: buffer SHALL reload the shift register in the same edge and be marked empty; a same-cycle frame handshake is not allowed, because frame_ready is low.
REQ-024 On the last bit of a non-final frame, buffer empty: SHALL enter ERR and set underrun.
REQ-025 After the last bit of frame NUM_FRAMES-1, SHALL enter FLUSH.
REQ-026 FLUSH: bit_in_CB=0, prgm_b=0, cb_prgm_b=1 for exactly PAD_BITS cycles, then FINISH.
REQ-027 FINISH (one cycle): prgm_b=1, cb_prgm_b=0, done=1; then IDLE.
REQ-028 ERR: prgm_b=1, cb_prgm_b=0, bit_in_CB=0; hold until start, which behaves as from IDLE.
REQ-029 busy SHALL be 1 in PRIME, SHIFT, FLUSH; 0 otherwise.
REQ-030 Frames offered with frame_ready low SHALL NOT be consumed; extra frames after NUM_FRAMES SHALL NOT be accepted.
REQ-031 Bit counter SHALL be width clog2(FRAME_BITS) and wrap to 0 at FRAME_BITS-1; frame counter SHALL be width clog2(NUM_FRAMES+1).
REQ-032 start while busy SHALL be ignored.

Reset
REQ-033 reset SHALL force IDLE, prgm_b=1, cb_prgm_b=0, bit_in_CB=0, frame_ready=0, busy=0, done=0, underrun=0, buffer empty, counters 0; reset mid-session SHALL abort without a done pulse.

Structure
REQ-034 FSM state encoding and default FRAME_BITS/NUM_FRAMES/PAD_BITS constants SHALL reside in shared package config_pkg.
REQ-035 Prefetch buffer SHALL be sub-module cfg_frame_buf (one-entry valid/ready register); serializer and FSM stay in top.

Verification
REQ-036 Frames 26'b11010000000000000000000011, 26'b10110000000000000000000001, 26'b11100000000000000000000001 pre-presented, start -> 78 contiguous bits LSB-first, then 2 zeros, then prgm_b=1/cb_prgm_b=0 and done pulse; total 81 cycles from first SHIFT to done.
REQ-037 Frame 1 withheld past frame-0 last bit -> ERR at cycle 26, underrun=1, cb_prgm_b=0, no done.
REQ-038 Reset asserted at SHIFT cycle 40 -> next cycle all outputs at reset values, buffer empty.
REQ-039 start pulsed during SHIFT -> no effect on stream or counters.
REQ-040 frame_valid held high throughout -> exactly NUM_FRAMES handshakes, frame_ready never high in FLUSH/FINISH/IDLE.
REQ-041 Back-to-back sessions: start in the cycle after done -> second session is bit-identical to the first.
